// File: rtl/dcf77_clock_v2.sv
// dcf77_clock_v2: free-running BCD calendar clock disciplined by DCF77 minute
// frames, with plausibility filtering, leap-second insertion and holdover status.
module dcf77_clock_v2 #(
  parameter int TICKS_PER_SEC = 100,
  parameter int SYNC_PRESET   = 7,
  parameter int HOLDOVER_S    = 86400
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       dcf77_sync,
  input  logic [7:0] dcf77_year,
  input  logic [7:0] dcf77_month,
  input  logic [7:0] dcf77_day,
  input  logic [2:0] dcf77_day_of_week,
  input  logic [7:0] dcf77_hour,
  input  logic [7:0] dcf77_minute,
  input  logic       dcf77_leap_announce,
  output logic [7:0] year,
  output logic [7:0] month,
  output logic [7:0] day,
  output logic [2:0] day_of_week,
  output logic [7:0] hour,
  output logic [7:0] minute,
  output logic [7:0] second,
  output logic       second_tick,
  output logic       synced,
  output logic       sync_rejected
);

  localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int HOLD_W = $clog2(HOLDOVER_S + 1);
  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [TICK_W-1:0] TICK_PRESET = TICK_W'(SYNC_PRESET);
  localparam logic [HOLD_W-1:0] HOLD_MAX    = HOLD_W'(HOLDOVER_S);

  function automatic logic [6:0] bcd2bin(input logic [7:0] v);
    return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
  endfunction

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // year = 10*t + o, so year mod 4 = (2*t + o) mod 4
  function automatic logic is_leap(input logic [7:0] y);
    return (2'({y[4], 1'b0}) + y[1:0]) == 2'd0;
  endfunction

  function automatic logic [4:0] month_days(input logic [6:0] mon, input logic leap);
    case (mon)
      7'd2:                    return leap ? 5'd29 : 5'd28;
      7'd4, 7'd6, 7'd9, 7'd11: return 5'd30;
      default:                 return 5'd31;
    endcase
  endfunction

  logic [TICK_W-1:0] tick_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              leap_pending;

  logic [6:0] in_month_bin, in_day_bin, in_hour_bin, in_minute_bin;
  logic       plausible, accept, reject, last_tick, advance;

  always_comb begin
    in_month_bin  = bcd2bin(dcf77_month);
    in_day_bin    = bcd2bin(dcf77_day);
    in_hour_bin   = bcd2bin(dcf77_hour);
    in_minute_bin = bcd2bin(dcf77_minute);
    plausible = bcd_ok(dcf77_year) && bcd_ok(dcf77_month) && bcd_ok(dcf77_day) &&
                bcd_ok(dcf77_hour) && bcd_ok(dcf77_minute) &&
                (in_month_bin >= 7'd1) && (in_month_bin <= 7'd12) &&
                (in_hour_bin <= 7'd23) && (in_minute_bin <= 7'd59) &&
                (dcf77_day_of_week != 3'd0) && (in_day_bin >= 7'd1) &&
                (in_day_bin <= {2'b00, month_days(in_month_bin, is_leap(dcf77_year))});
    accept    = clk_en && dcf77_sync && plausible;
    reject    = clk_en && dcf77_sync && !plausible;
    last_tick = (tick_cnt == TICK_LAST);
    advance   = clk_en && last_tick && !accept;
  end

  logic       leap_insert, min_carry, hour_carry, day_carry, month_carry, year_carry;
  logic [7:0] year_nxt, month_nxt, day_nxt, hour_nxt, minute_nxt, second_nxt;
  logic [2:0] dow_nxt;

  // Full carry chain resolved combinationally so one tick can roll every field.
  always_comb begin
    leap_insert = leap_pending && (minute == 8'h59) && (second == 8'h59);
    min_carry   = (second == 8'h60) || ((second == 8'h59) && !leap_insert);
    hour_carry  = min_carry && (minute == 8'h59);
    day_carry   = hour_carry && (hour == 8'h23);
    month_carry = day_carry &&
                  ({2'b00, month_days(bcd2bin(month), is_leap(year))} == bcd2bin(day));
    year_carry  = month_carry && (month == 8'h12);

    second_nxt = leap_insert ? 8'h60 : (min_carry ? 8'h00 : bcd_inc(second));
    minute_nxt = minute;
    hour_nxt   = hour;
    day_nxt    = day;
    dow_nxt    = day_of_week;
    month_nxt  = month;
    year_nxt   = year;
    if (min_carry)  minute_nxt = hour_carry ? 8'h00 : bcd_inc(minute);
    if (hour_carry) hour_nxt   = day_carry ? 8'h00 : bcd_inc(hour);
    if (day_carry) begin
      day_nxt = month_carry ? 8'h01 : bcd_inc(day);
      dow_nxt = (day_of_week == 3'd7) ? 3'd1 : day_of_week + 3'd1;
    end
    if (month_carry) month_nxt = year_carry ? 8'h01 : bcd_inc(month);
    if (year_carry)  year_nxt  = (year == 8'h99) ? 8'h00 : bcd_inc(year);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      year          <= 8'h00;
      month         <= 8'h01;
      day           <= 8'h01;
      day_of_week   <= 3'd1;
      hour          <= 8'h00;
      minute        <= 8'h00;
      second        <= 8'h00;
      tick_cnt      <= '0;
      hold_cnt      <= '0;
      leap_pending  <= 1'b0;
      synced        <= 1'b0;
      second_tick   <= 1'b0;
      sync_rejected <= 1'b0;
    end else begin
      second_tick   <= advance;
      sync_rejected <= reject;
      if (accept) begin
        year         <= dcf77_year;
        month        <= dcf77_month;
        day          <= dcf77_day;
        day_of_week  <= dcf77_day_of_week;
        hour         <= dcf77_hour;
        minute       <= dcf77_minute;
        second       <= 8'h00;
        tick_cnt     <= TICK_PRESET;
        hold_cnt     <= '0;
        synced       <= 1'b1;
        leap_pending <= dcf77_leap_announce;
      end else if (clk_en) begin
        tick_cnt <= last_tick ? '0 : tick_cnt + TICK_W'(1);
        if (last_tick) begin
          year        <= year_nxt;
          month       <= month_nxt;
          day         <= day_nxt;
          day_of_week <= dow_nxt;
          hour        <= hour_nxt;
          minute      <= minute_nxt;
          second      <= second_nxt;
          if (second == 8'h60) leap_pending <= 1'b0;
          if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
            if (hold_cnt + HOLD_W'(1) == HOLD_MAX) synced <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dcf77_clock_v2.sv
// Bench for dcf77_clock_v2: plausibility vector table plus directed roll-over,
// leap-second, holdover and async-reset sequences (10 ticks/s, 3 s holdover).
module tb_dcf77_clock_v2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_en;
  logic       dcf77_sync;
  logic [7:0] dcf77_year, dcf77_month, dcf77_day, dcf77_hour, dcf77_minute;
  logic [2:0] dcf77_day_of_week;
  logic       dcf77_leap_announce;
  logic [7:0] year, month, day, hour, minute, second;
  logic [2:0] day_of_week;
  logic       second_tick, synced, sync_rejected;

  dcf77_clock_v2 #(
    .TICKS_PER_SEC(10),
    .SYNC_PRESET  (7),
    .HOLDOVER_S   (3)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .clk_en             (clk_en),
    .dcf77_sync         (dcf77_sync),
    .dcf77_year         (dcf77_year),
    .dcf77_month        (dcf77_month),
    .dcf77_day          (dcf77_day),
    .dcf77_day_of_week  (dcf77_day_of_week),
    .dcf77_hour         (dcf77_hour),
    .dcf77_minute       (dcf77_minute),
    .dcf77_leap_announce(dcf77_leap_announce),
    .year               (year),
    .month              (month),
    .day                (day),
    .day_of_week        (day_of_week),
    .hour               (hour),
    .minute             (minute),
    .second             (second),
    .second_tick        (second_tick),
    .synced             (synced),
    .sync_rejected      (sync_rejected)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int st_count = 0;

  always @(negedge clk) if (second_tick === 1'b1) st_count = st_count + 1;

  typedef struct {
    logic [7:0] y, mo, d;
    logic [2:0] dow;
    logic [7:0] h, mi;
    logic       ok;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic logic [42:0] pk(input logic [7:0] y, mo, d, input logic [2:0] dow,
                                     input logic [7:0] h, mi, s);
    return {y, mo, d, dow, h, mi, s};
  endfunction

  function automatic logic [42:0] dut_time();
    return {year, month, day, day_of_week, hour, minute, second};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) clk_en = 1'b1;
      @(negedge clk) clk_en = 1'b0;
    end
  endtask

  task automatic set_frame(input logic [7:0] y, mo, d, input logic [2:0] dow,
                           input logic [7:0] h, mi, input logic leap);
    dcf77_year = y; dcf77_month = mo; dcf77_day = d; dcf77_day_of_week = dow;
    dcf77_hour = h; dcf77_minute = mi; dcf77_leap_announce = leap;
  endtask

  task automatic do_sync(input logic [7:0] y, mo, d, input logic [2:0] dow,
                         input logic [7:0] h, mi, input logic leap);
    @(negedge clk);
    set_frame(y, mo, d, dow, h, mi, leap);
    dcf77_sync = 1'b1;
    clk_en     = 1'b1;
    @(negedge clk);
    dcf77_sync = 1'b0;
    clk_en     = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{8'h24, 8'h02, 8'h29, 3'd4, 8'h10, 8'h20, 1'b1};
    vecs[1]  = '{8'h23, 8'h02, 8'h29, 3'd3, 8'h10, 8'h20, 1'b0};
    vecs[2]  = '{8'h23, 8'h02, 8'h28, 3'd2, 8'h10, 8'h20, 1'b1};
    vecs[3]  = '{8'h24, 8'h04, 8'h31, 3'd3, 8'h10, 8'h20, 1'b0};
    vecs[4]  = '{8'h24, 8'h04, 8'h30, 3'd2, 8'h10, 8'h20, 1'b1};
    vecs[5]  = '{8'h24, 8'h05, 8'h31, 3'd5, 8'h10, 8'h20, 1'b1};
    vecs[6]  = '{8'h24, 8'h06, 8'h31, 3'd1, 8'h10, 8'h20, 1'b0};
    vecs[7]  = '{8'h24, 8'h07, 8'h15, 3'd1, 8'h10, 8'h6A, 1'b0};
    vecs[8]  = '{8'h24, 8'h07, 8'h15, 3'd1, 8'h24, 8'h00, 1'b0};
    vecs[9]  = '{8'h24, 8'h07, 8'h15, 3'd1, 8'h23, 8'h59, 1'b1};
    vecs[10] = '{8'h24, 8'h13, 8'h15, 3'd1, 8'h10, 8'h20, 1'b0};
    vecs[11] = '{8'h24, 8'h00, 8'h15, 3'd1, 8'h10, 8'h20, 1'b0};
    vecs[12] = '{8'h24, 8'h0A, 8'h15, 3'd1, 8'h10, 8'h20, 1'b0};
    vecs[13] = '{8'h24, 8'h07, 8'h00, 3'd1, 8'h10, 8'h20, 1'b0};
    vecs[14] = '{8'h24, 8'h07, 8'h1A, 3'd1, 8'h10, 8'h20, 1'b0};
    vecs[15] = '{8'h24, 8'h07, 8'h15, 3'd0, 8'h10, 8'h20, 1'b0};
    vecs[16] = '{8'h00, 8'h02, 8'h29, 3'd7, 8'h10, 8'h20, 1'b1};
    vecs[17] = '{8'h9A, 8'h07, 8'h15, 3'd1, 8'h10, 8'h20, 1'b0};
    vecs[18] = '{8'h00, 8'h01, 8'h32, 3'd1, 8'h10, 8'h20, 1'b0};
    vecs[19] = '{8'h99, 8'h12, 8'h31, 3'd7, 8'h23, 8'h59, 1'b1};

    rst_n = 1'b0;
    clk_en = 1'b0;
    dcf77_sync = 1'b0;
    set_frame(8'h00, 8'h00, 8'h00, 3'd0, 8'h00, 8'h00, 1'b0);

    #12;
    check("reset_time", dut_time(), pk(8'h00, 8'h01, 8'h01, 3'd1, 8'h00, 8'h00, 8'h00));
    check("reset_flags", {second_tick, synced, sync_rejected}, 3'b000);
    @(negedge clk) rst_n = 1'b1;

    // first second after reset
    tick_n(9);
    check("nine_ticks_second", second, 8'h00);
    tick_n(1);
    check("ten_ticks_time", dut_time(), pk(8'h00, 8'h01, 8'h01, 3'd1, 8'h00, 8'h00, 8'h01));
    check("ten_ticks_stick", second_tick, 1'b1);
    #1;
    check("ten_ticks_stick_count", st_count, 1);
    check("ten_ticks_synced", synced, 1'b0);

    // sync strobes without clk_en are ignored
    @(negedge clk);
    set_frame(8'h24, 8'h02, 8'h28, 3'd3, 8'h23, 8'h59, 1'b0);
    dcf77_sync = 1'b1;
    @(negedge clk);
    set_frame(8'h24, 8'h13, 8'h28, 3'd3, 8'h23, 8'h59, 1'b0);
    @(negedge clk) dcf77_sync = 1'b0;
    check("noen_time", dut_time(), pk(8'h00, 8'h01, 8'h01, 3'd1, 8'h00, 8'h00, 8'h01));
    check("noen_flags", {synced, sync_rejected}, 2'b00);

    // leap-year February rollover
    do_sync(8'h24, 8'h02, 8'h28, 3'd3, 8'h23, 8'h59, 1'b0);
    check("feb_sync_time", dut_time(), pk(8'h24, 8'h02, 8'h28, 3'd3, 8'h23, 8'h59, 8'h00));
    check("feb_sync_flags", {synced, sync_rejected}, 2'b10);
    tick_n(592);
    check("feb_pre_time", dut_time(), pk(8'h24, 8'h02, 8'h28, 3'd3, 8'h23, 8'h59, 8'h59));
    tick_n(1);
    check("feb_roll_time", dut_time(), pk(8'h24, 8'h02, 8'h29, 3'd4, 8'h00, 8'h00, 8'h00));
    check("feb_roll_synced", synced, 1'b0);

    // holdover expiry on the third second
    do_sync(8'h10, 8'h06, 8'h15, 3'd2, 8'h12, 8'h34, 1'b0);
    #1 st_count = 0;
    tick_n(13);
    check("hold_2s_synced", synced, 1'b1);
    tick_n(9);
    check("hold_pre_synced", synced, 1'b1);
    tick_n(1);
    check("hold_3s_tick_synced", {second_tick, synced}, 2'b10);
    #1;
    check("hold_3s_tick_count", st_count, 3);

    // leap second: pending through 58:59, inserted at 59:59
    do_sync(8'h10, 8'h06, 8'h15, 3'd2, 8'h12, 8'h58, 1'b1);
    tick_n(593);
    check("leap_5900", dut_time(), pk(8'h10, 8'h06, 8'h15, 3'd2, 8'h12, 8'h59, 8'h00));
    tick_n(590);
    check("leap_5959", dut_time(), pk(8'h10, 8'h06, 8'h15, 3'd2, 8'h12, 8'h59, 8'h59));
    tick_n(10);
    check("leap_5960", dut_time(), pk(8'h10, 8'h06, 8'h15, 3'd2, 8'h12, 8'h59, 8'h60));
    tick_n(10);
    check("leap_1300", dut_time(), pk(8'h10, 8'h06, 8'h15, 3'd2, 8'h13, 8'h00, 8'h00));

    // century and month-length rollovers
    do_sync(8'h99, 8'h12, 8'h31, 3'd7, 8'h23, 8'h59, 1'b0);
    tick_n(593);
    check("century_roll", dut_time(), pk(8'h00, 8'h01, 8'h01, 3'd1, 8'h00, 8'h00, 8'h00));
    do_sync(8'h23, 8'h04, 8'h30, 3'd7, 8'h23, 8'h59, 1'b0);
    tick_n(593);
    check("apr_roll", dut_time(), pk(8'h23, 8'h05, 8'h01, 3'd1, 8'h00, 8'h00, 8'h00));
    do_sync(8'h23, 8'h02, 8'h28, 3'd2, 8'h23, 8'h59, 1'b0);
    tick_n(593);
    check("feb23_roll", dut_time(), pk(8'h23, 8'h03, 8'h01, 3'd3, 8'h00, 8'h00, 8'h00));

    // plausibility table: each vector follows a fresh base sync
    for (int i = 0; i < NV; i++) begin
      do_sync(8'h10, 8'h06, 8'h15, 3'd2, 8'h12, 8'h34, 1'b0);
      do_sync(vecs[i].y, vecs[i].mo, vecs[i].d, vecs[i].dow, vecs[i].h, vecs[i].mi, 1'b0);
      check($sformatf("vec%0d_rejected", i), sync_rejected, !vecs[i].ok);
      if (vecs[i].ok)
        check($sformatf("vec%0d_time", i), dut_time(),
              pk(vecs[i].y, vecs[i].mo, vecs[i].d, vecs[i].dow, vecs[i].h, vecs[i].mi, 8'h00));
      else
        check($sformatf("vec%0d_time", i), dut_time(),
              pk(8'h10, 8'h06, 8'h15, 3'd2, 8'h12, 8'h34, 8'h00));
      check($sformatf("vec%0d_synced", i), synced, 1'b1);
      @(negedge clk);
      check($sformatf("vec%0d_rej_clear", i), sync_rejected, 1'b0);
    end

    // asynchronous reset between clock edges
    do_sync(8'h24, 8'h07, 8'h15, 3'd1, 8'h10, 8'h20, 1'b0);
    tick_n(4);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_time", dut_time(), pk(8'h00, 8'h01, 8'h01, 3'd1, 8'h00, 8'h00, 8'h00));
    check("async_rst_flags", {second_tick, synced, sync_rejected}, 3'b000);
    @(negedge clk) rst_n = 1'b1;
    tick_n(10);
    check("post_rst_second", dut_time(), pk(8'h00, 8'h01, 8'h01, 3'd1, 8'h00, 8'h00, 8'h01));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
